data_mem_ctrl: RTL and testbench



---
 rtl/data_mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Wait-state data memory controller for the MEM stage. It accepts one request
// at a time on the DataMem_* handshake, waits LATENCY clock edges, then
// performs the access on an internal word-addressed SRAM array. Writes update
// only the selected byte lanes. Reads return the stored word with unselected
// lanes forced to zero. Out-of-range addresses and empty byte selects are
// flagged as errors.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, at most 2**29)
//   LATENCY  edges from acceptance to access (1..15)
//
// Ports
//   clk              clock
//   rst              synchronous active-high reset
//   DataMem_access   request valid
//   DataMem_RW       1 = write, 0 = read
//   DataMem_Select   byte-lane enables, bit i covers bits [8i+7:8i]
//   DataMem_Address  byte address; word index = [ADDR_W+1:2]
//   WriteDataMem     write data
//   ReadDataMem      registered read data
//   DataMem_Ready    one-cycle completion pulse
//   DataMem_Error    error flag, qualified by DataMem_Ready
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DataMem_access,
  input  logic        DataMem_RW,
  input  logic [3:0]  DataMem_Select,
  input  logic [31:0] DataMem_Address,
  input  logic [31:0] WriteDataMem,
  output logic [31:0] ReadDataMem,
  output logic        DataMem_Ready,
  output logic        DataMem_Error
);

  localparam int ADDR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Request captured at acceptance; the requester is free to change its
  // inputs afterwards.
  logic              rw_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] idx_q;
  logic [31:0]       wdata_q;
  logic              valid_q;

  logic        accept;
  logic        do_access;
  logic        req_valid;
  logic [31:0] lane_mask;

  logic [31:0] mem [DEPTH];

  logic [31:0] rdata_q;
  logic        ready_q;
  logic        error_q;

  // Any address bit above the array range makes the request invalid, as does
  // an empty byte select. Evaluated on the live inputs at acceptance.
  assign req_valid = ((DataMem_Address >> (ADDR_W + 2)) == 32'd0) &&
                     (DataMem_Select != 4'b0000);

  // Expand the captured byte selects into a 32-bit lane mask.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane_mask
      assign lane_mask[8*gi +: 8] = {8{sel_q[gi]}};
    end
  endgenerate

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (DataMem_access) accept = 1'b1;
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // A request present in the Ready cycle is a new one (back-to-back).
        if (DataMem_access) accept = 1'b1;
        else                state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      state_d = BUSY;
      cnt_d   = 4'(LATENCY - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      sel_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rw_q    <= DataMem_RW;
        sel_q   <= DataMem_Select;
        idx_q   <= DataMem_Address[ADDR_W+1:2];
        wdata_q <= WriteDataMem;
        valid_q <= req_valid;
      end
    end
  end

  // Array write port; contents survive reset, but a reset on the access
  // edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && do_access && rw_q && valid_q) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  // Response registers. ReadDataMem keeps its value across valid writes and
  // DataMem_Error is held between Ready pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      ready_q <= do_access;
      if (do_access) begin
        if (!valid_q) begin
          rdata_q <= 32'd0;
          error_q <= 1'b1;
        end else begin
          error_q <= 1'b0;
          if (!rw_q) rdata_q <= mem[idx_q] & lane_mask;
        end
      end
    end
  end

  assign ReadDataMem   = rdata_q;
  assign DataMem_Ready = ready_q;
  assign DataMem_Error = error_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//
// Directed bench for data_mem_ctrl with DEPTH=1024, LATENCY=2. Inputs are
// driven 1 time unit after a rising edge and outputs are sampled at the same
// point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int TIMEOUT = 20;

  logic        clk;
  logic        rst;
  logic        DataMem_access;
  logic        DataMem_RW;
  logic [3:0]  DataMem_Select;
  logic [31:0] DataMem_Address;
  logic [31:0] WriteDataMem;
  logic [31:0] ReadDataMem;
  logic        DataMem_Ready;
  logic        DataMem_Error;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [4:0]  ready_hist;

  data_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk             (clk),
    .rst             (rst),
    .DataMem_access  (DataMem_access),
    .DataMem_RW      (DataMem_RW),
    .DataMem_Select  (DataMem_Select),
    .DataMem_Address (DataMem_Address),
    .WriteDataMem    (WriteDataMem),
    .ReadDataMem     (ReadDataMem),
    .DataMem_Ready   (DataMem_Ready),
    .DataMem_Error   (DataMem_Error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("vec %0d %s: observed %h expected %h", vectors, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction starting from IDLE. Inputs are scrambled right after
  // acceptance to show the request was captured. Returns the edge count from
  // acceptance to the Ready sample (TIMEOUT if Ready never came).
  task automatic txn(input logic rw, input logic [3:0] sel, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rdata,
                     output logic err, output int edges);
    DataMem_access  = 1'b1;
    DataMem_RW      = rw;
    DataMem_Select  = sel;
    DataMem_Address = addr;
    WriteDataMem    = wdata;
    step();
    DataMem_access  = 1'b0;
    DataMem_RW      = ~rw;
    DataMem_Select  = 4'b0000;
    DataMem_Address = 32'hFFFF_FFFF;
    WriteDataMem    = 32'h0BAD_0BAD;
    edges = 0;
    do begin
      step();
      edges++;
    end while (!DataMem_Ready && edges < TIMEOUT);
    rdata = ReadDataMem;
    err   = DataMem_Error;
    step();
  endtask

  initial begin
    rst             = 1'b1;
    DataMem_access  = 1'b0;
    DataMem_RW      = 1'b0;
    DataMem_Select  = 4'b0000;
    DataMem_Address = 32'd0;
    WriteDataMem    = 32'd0;

    // Reset for two cycles.
    step();
    step();
    chk("reset_ready", {31'd0, DataMem_Ready}, 32'd0);
    chk("reset_error", {31'd0, DataMem_Error}, 32'd0);
    chk("reset_rdata", ReadDataMem, 32'd0);
    rst = 1'b0;
    step();

    // Full-word write then read.
    txn(1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    chk("wr10_latency", lat, LATENCY);
    chk("wr10_error", {31'd0, er}, 32'd0);
    chk("wr10_rdata_unchanged", rd, 32'd0);
    txn(1'b0, 4'b1111, 32'h10, 32'd0, rd, er, lat);
    chk("rd10_latency", lat, LATENCY);
    chk("rd10_data", rd, 32'hDEAD_BEEF);
    chk("rd10_error", {31'd0, er}, 32'd0);

    // Byte lanes.
    txn(1'b1, 4'b1111, 32'h20, 32'h1122_3344, rd, er, lat);
    txn(1'b1, 4'b0010, 32'h20, 32'hAABB_CCDD, rd, er, lat);
    chk("wr20_lane_rdata_unchanged", rd, 32'hDEAD_BEEF);
    txn(1'b0, 4'b1111, 32'h20, 32'd0, rd, er, lat);
    chk("rd20_sel1111", rd, 32'h1122_CC44);
    txn(1'b0, 4'b1100, 32'h20, 32'd0, rd, er, lat);
    chk("rd20_sel1100", rd, 32'h1122_0000);
    txn(1'b0, 4'b0001, 32'h23, 32'd0, rd, er, lat);
    chk("rd23_low_bits_ignored", rd, 32'h0000_0044);

    // Last word of the array.
    txn(1'b1, 4'b1111, 32'hFFC, 32'hCAFE_F00D, rd, er, lat);
    chk("wr_last_error", {31'd0, er}, 32'd0);
    txn(1'b0, 4'b1111, 32'hFFC, 32'd0, rd, er, lat);
    chk("rd_last_data", rd, 32'hCAFE_F00D);

    // Errors.
    txn(1'b0, 4'b1111, 32'h1000, 32'd0, rd, er, lat);
    chk("rd1000_error", {31'd0, er}, 32'd1);
    chk("rd1000_rdata", rd, 32'd0);
    chk("rd1000_latency", lat, LATENCY);
    txn(1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF, rd, er, lat);
    chk("wr_sel0_error", {31'd0, er}, 32'd1);
    chk("error_held_after_ready", {31'd0, DataMem_Error}, 32'd1);
    txn(1'b0, 4'b1111, 32'h20, 32'd0, rd, er, lat);
    chk("rd20_after_sel0_write", rd, 32'h1122_CC44);
    chk("rd20_error_cleared", {31'd0, er}, 32'd0);

    // Back-to-back: write 0x40 accepted at E0, read 0x40 held on the bus and
    // accepted in the RESP cycle.
    DataMem_access  = 1'b1;
    DataMem_RW      = 1'b1;
    DataMem_Select  = 4'b1111;
    DataMem_Address = 32'h40;
    WriteDataMem    = 32'hA5A5_A5A5;
    step();
    DataMem_RW      = 1'b0;
    WriteDataMem    = 32'd0;
    for (int i = 0; i < 5; i++) begin
      step();
      ready_hist[i] = DataMem_Ready;
    end
    rd = ReadDataMem;
    er = DataMem_Error;
    DataMem_access = 1'b0;
    chk("b2b_ready_pattern", {27'd0, ready_hist}, 32'b10010);
    chk("b2b_read_data", rd, 32'hA5A5_A5A5);
    chk("b2b_error", {31'd0, er}, 32'd0);
    step();
    step();
    chk("b2b_idle_no_ready", {31'd0, DataMem_Ready}, 32'd0);

    // Reset mid-operation.
    txn(1'b1, 4'b1111, 32'h30, 32'h1234_5678, rd, er, lat);
    DataMem_access  = 1'b1;
    DataMem_RW      = 1'b1;
    DataMem_Select  = 4'b1111;
    DataMem_Address = 32'h30;
    WriteDataMem    = 32'h0000_0055;
    step();
    DataMem_access  = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready_hist = 5'd0;
    for (int i = 0; i < 5; i++) begin
      ready_hist[i] = DataMem_Ready;
      step();
    end
    chk("abort_no_ready", {27'd0, ready_hist}, 32'd0);
    chk("abort_rdata_reset", ReadDataMem, 32'd0);
    txn(1'b0, 4'b1111, 32'h30, 32'd0, rd, er, lat);
    chk("rd30_after_abort", rd, 32'h1234_5678);
    chk("rd30_latency", lat, LATENCY);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
